vid_text_pixgen: RTL

Text-mode pixel generator for the video path. It walks the 64×16 video RAM once per scanline and turns each character code into an 11-bit glyph address for the font ROM (8 rows per glyph). It then loads the returned glyph byte into a shifter and emits one pixel per clock to the video output stage. It sits between the video-timing generator, which supplies line and frame pulses, and the downstream sync/DAC logic. It supports 64-column normal mode and 32-column double-width mode.

---
 rtl/vid_text_pixgen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vid_text_pixgen.sv
// Text-mode pixel generator: walks one text row of video RAM per scanline,
// turns character codes into font ROM addresses and serializes glyph rows.
module vid_text_pixgen #(
    parameter int COLS    = 64,
    parameter int ROWS    = 16,
    parameter int LINE_H  = 12,
    parameter int VRAM_AW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               line_start,
    input  logic               wide_mode,
    input  logic               invert,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_data,
    output logic [10:0]        font_addr,
    output logic               font_ce,
    input  logic [7:0]         font_data,
    output logic               pix,
    output logic               pix_valid,
    output logic               line_done
);
    localparam int CW   = $clog2(COLS);
    localparam int RW   = VRAM_AW - CW;
    localparam int SW   = (LINE_H > 8) ? $clog2(LINE_H) : 3;
    // cnt is 0 in the cycle after line_start; pixels occupy cnt 5..LAST
    localparam int LAST = COLS * 8 + 4;
    localparam int NW   = $clog2(LAST + 2);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic              wide_q, wide_d, inv_q, inv_d;
    logic [4:0]        vld_pipe_q, vld_pipe_d;
    logic [7:0]        sh_q, sh_d;
    logic [VRAM_AW-1:0] vaddr_q, vaddr_d;
    logic [10:0]       faddr_q, faddr_d;
    logic              fce_q, fce_d, pix_q, pix_d, pv_q, pv_d, done_q, done_d;
    logic [7:0]        glyph;
    logic              slot_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            scan_q     <= '0;
            wide_q     <= 1'b0;
            inv_q      <= 1'b0;
            vld_pipe_q <= '0;
            sh_q       <= '0;
            vaddr_q    <= '0;
            faddr_q    <= '0;
            fce_q      <= 1'b0;
            pix_q      <= 1'b0;
            pv_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            scan_q     <= scan_d;
            wide_q     <= wide_d;
            inv_q      <= inv_d;
            vld_pipe_q <= vld_pipe_d;
            sh_q       <= sh_d;
            vaddr_q    <= vaddr_d;
            faddr_q    <= faddr_d;
            fce_q      <= fce_d;
            pix_q      <= pix_d;
            pv_q       <= pv_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        scan_d     = scan_q;
        wide_d     = wide_q;
        inv_d      = inv_q;
        vld_pipe_d = {vld_pipe_q[3:0], 1'b0};
        sh_d       = sh_q;
        vaddr_d    = vaddr_q;
        faddr_d    = faddr_q;
        fce_d      = 1'b0;
        pix_d      = pix_q;
        glyph      = 8'h00;
        slot_end   = wide_q ? (cnt_q[3:0] == 4'hF) : (cnt_q[2:0] == 3'h7);
        done_d     = (state_q == DRAIN) && (cnt_q == NW'(LAST)) && !line_start;

        if (frame_start) begin
            row_d  = '0;
            scan_d = '0;
        end else if (done_d) begin
            if (scan_q == SW'(LINE_H - 1)) begin
                scan_d = '0;
                row_d  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                scan_d = scan_q + 1'b1;
            end
        end

        if (state_q != IDLE) cnt_d = cnt_q + 1'b1;

        case (state_q)
            FETCH: if (slot_end) begin
                col_d         = col_q + (wide_q ? CW'(2) : CW'(1));
                vaddr_d       = {row_d, col_d};
                vld_pipe_d[0] = 1'b1;
                if (col_d == (wide_q ? CW'(COLS - 2) : CW'(COLS - 1))) state_d = DRAIN;
            end
            DRAIN: if (cnt_q == NW'(LAST)) state_d = IDLE;
            default: ;
        endcase

        // vram_data belongs to the address issued one cycle earlier
        if (vld_pipe_q[1]) begin
            faddr_d = {vram_data, scan_d[2:0]};
            fce_d   = 1'b1;
        end

        pv_d = (state_q != IDLE) && (cnt_q >= NW'(4)) && (cnt_q < NW'(LAST));
        if (vld_pipe_q[4]) begin
            glyph = (int'(scan_d) >= 8) ? 8'h00 : font_data;
            sh_d  = glyph;
            pix_d = glyph[7] ^ inv_q;
        end else if (!wide_q || !cnt_q[0]) begin
            sh_d  = {sh_q[6:0], 1'b0};
            pix_d = sh_q[6] ^ inv_q;
        end
        if (!pv_d) pix_d = 1'b0;

        // a new line always wins, flushing whatever is in flight
        if (line_start) begin
            state_d    = FETCH;
            cnt_d      = '0;
            col_d      = '0;
            wide_d     = wide_mode;
            inv_d      = invert;
            vaddr_d    = {row_d, CW'(0)};
            vld_pipe_d = 5'b00001;
            fce_d      = 1'b0;
            pv_d       = 1'b0;
            pix_d      = 1'b0;
        end
    end

    assign vram_addr = vaddr_q;
    assign font_addr = faddr_q;
    assign font_ce   = fce_q;
    assign pix       = pix_q;
    assign pix_valid = pv_q;
    assign line_done = done_q;
endmodule
